// File: rtl/branch_redirect_ctrl_if.sv
// Fetch / execute / predictor-update signal bundle for branch_redirect_ctrl.
// The slave modport is the controller's view; master is the pipeline-side view.
interface branch_redirect_ctrl_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pred_target;
  logic        if_pred_taken;
  logic        if_stall;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_is_branch;
  logic        ex_taken;
  logic        ex_stall;

  logic        flush;
  logic [31:0] redirect_pc;

  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;

  modport slave (
    input  if_valid, if_pc, if_pred_target, if_pred_taken,
    input  ex_valid, ex_pc, ex_target, ex_is_branch, ex_taken,
    input  upd_ready,
    output if_stall, ex_stall, flush, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken
  );

  modport master (
    output if_valid, if_pc, if_pred_target, if_pred_taken,
    output ex_valid, ex_pc, ex_target, ex_is_branch, ex_taken,
    output upd_ready,
    input  if_stall, ex_stall, flush, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Tracks in-flight branch predictions, detects mispredicts at EX, issues a
// one-cycle flush/redirect and a single-entry BHT update handshake.
module branch_redirect_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  branch_redirect_ctrl_if.slave bus,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     br_cnt,
  output logic [CNT_W-1:0]     mp_cnt,
  output logic                 q_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_rec_t;

  typedef enum logic {IDLE, UPD_WAIT} state_e;

  pred_rec_t          mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e             state_q, state_d;
  logic               flush_q, flush_d;
  logic [31:0]        redirect_q, redirect_d;
  logic [31:0]        upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
  logic               upd_taken_q, upd_taken_d;
  logic [CNT_W-1:0]   br_q, br_d, mp_q, mp_d;
  logic               q_err_q, q_err_d;

  logic               fifo_full, fifo_empty, push, pop, ex_accept;
  logic               head_hit, pred_taken_eff, mispredict;
  pred_rec_t          head;

  assign fifo_full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // Full blocks a push even when EX pops in the same cycle.
  assign bus.if_stall = fifo_full || flush_q;
  assign bus.ex_stall = (state_q == UPD_WAIT);
  assign push         = bus.if_valid && !bus.if_stall;
  assign ex_accept    = bus.ex_valid && !bus.ex_stall;
  assign pop          = ex_accept && !fifo_empty;

  // A missing or mismatched head record is treated as a not-taken prediction.
  assign head_hit       = !fifo_empty && (head.pc == bus.ex_pc);
  assign pred_taken_eff = head_hit && head.pred_taken;
  assign mispredict     = (bus.ex_taken != pred_taken_eff) ||
                          (bus.ex_taken && pred_taken_eff && (bus.ex_target != head.pred_target));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d     = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d     = rd_ptr_q + (AW+1)'(pop);
    flush_d      = ex_accept && mispredict;
    redirect_d   = redirect_q;
    state_d      = state_q;
    upd_pc_d     = upd_pc_q;
    upd_target_d = upd_target_q;
    upd_taken_d  = upd_taken_q;
    br_d         = br_q;
    mp_d         = mp_q;
    q_err_d      = q_err_q || (ex_accept && !head_hit);

    // The cycle after a mispredict the whole queue, including any same-cycle push, is dropped.
    if (flush_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    if (flush_d)
      redirect_d = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;

    case (state_q)
      IDLE: begin
        if (ex_accept && bus.ex_is_branch) begin
          state_d      = UPD_WAIT;
          upd_pc_d     = bus.ex_pc;
          upd_target_d = bus.ex_target;
          upd_taken_d  = bus.ex_taken;
        end
      end
      UPD_WAIT: begin
        if (bus.upd_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr_stats) begin
      br_d = '0;
      mp_d = '0;
    end else begin
      if (ex_accept && bus.ex_is_branch && (br_q != '1)) br_d = br_q + CNT_W'(1);
      if (ex_accept && mispredict && (mp_q != '1))       mp_d = mp_q + CNT_W'(1);
    end
  end

  // NOTE: the queue storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q[AW-1:0]] <= '{pc: bus.if_pc, pred_taken: bus.if_pred_taken,
                                   pred_target: bus.if_pred_target};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= IDLE;
      flush_q      <= 1'b0;
      redirect_q   <= '0;
      upd_pc_q     <= '0;
      upd_target_q <= '0;
      upd_taken_q  <= 1'b0;
      br_q         <= '0;
      mp_q         <= '0;
      q_err_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      state_q      <= state_d;
      flush_q      <= flush_d;
      redirect_q   <= redirect_d;
      upd_pc_q     <= upd_pc_d;
      upd_target_q <= upd_target_d;
      upd_taken_q  <= upd_taken_d;
      br_q         <= br_d;
      mp_q         <= mp_d;
      q_err_q      <= q_err_d;
    end
  end

  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_q;
  assign bus.upd_valid   = (state_q == UPD_WAIT);
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_target  = upd_target_q;
  assign bus.upd_taken   = upd_taken_q;
  assign br_cnt          = br_q;
  assign mp_cnt          = mp_q;
  assign q_err           = q_err_q;

endmodule
